spi_flash_rd_ctrl: RTL and testbench

Read-only SPI flash controller that sequences the external user flash on the mprj_io pins for the Microwatt core. It accepts 24-bit word-read requests over a valid/ready handshake. For each request it issues a Fast Read transaction (SPI mode 0) and returns one 32-bit little-endian word. It drives CSB, SCK and per-pin data with Caravel-style active-low output enables.

---
 rtl/spi_flash_rd_ctrl_pkg.sv | 26 ++
 rtl/spi_flash_rd_ctrl_sck_gen.sv | 40 ++++
 rtl/spi_flash_rd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_flash_rd_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_rd_ctrl_pkg.sv
// Shared types and constants for the SPI flash read controller.
// Package spi_flash_pkg: FSM state encoding, command opcodes, frame sizes.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        RESP,
        GAP
    } state_t;

    localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
    localparam logic [7:0]  CMD_QUAD_READ = 8'h6B;
    localparam int unsigned DUMMY_CYC     = 8;
    localparam int unsigned ADDR_BITS     = 24;
    localparam int unsigned DATA_BITS     = 32;

    // First byte off the wire sits in [31:24] of the shift register; return it in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_rd_ctrl_sck_gen.sv
// SCK generator: toggles SCK every CLK_DIV clocks while enabled, idles low.
// rise_stb/fall_stb flag the clock edge on which SCK will rise/fall.
module spi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic resetb,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    always_comb begin
        tick     = en && (cnt == CW'(CLK_DIV - 1));
        rise_stb = tick && !sck;
        fall_stb = tick && sck;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// Read-only SPI flash controller: one 24-bit word request -> one Fast Read frame (mode 0).
// Define SPI_FLASH_QUAD_EN for Quad Output Fast Read (0x6B, 4-bit data phase).
module spi_flash_rd_ctrl
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int CS_HIGH_CYC = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        flash_csb_o,
    output logic        flash_clk_o,
    output logic [3:0]  flash_io_o,
    output logic [3:0]  flash_io_oeb,
    input  logic [3:0]  flash_io_i
);

`ifdef SPI_FLASH_QUAD_EN
    localparam logic [7:0]  RD_CMD   = CMD_QUAD_READ;
    localparam int unsigned DATA_SCK = DATA_BITS / 4;
    localparam logic [3:0]  RX_OEB   = 4'b1111;
`else
    localparam logic [7:0]  RD_CMD   = CMD_FAST_READ;
    localparam int unsigned DATA_SCK = DATA_BITS;
    localparam logic [3:0]  RX_OEB   = 4'b0011;
`endif

    localparam int GW = $clog2(CS_HIGH_CYC + 1);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [31:0]   rx_sr;
    logic [31:0]   rx_next;
    logic          sck_en;
    logic          sck_rise;
    logic          sck_fall;

    always_comb begin
        sck_en = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
`ifdef SPI_FLASH_QUAD_EN
        rx_next = {rx_sr[27:0], flash_io_i};
`else
        rx_next = {rx_sr[30:0], |(flash_io_i & 4'b0010)};
`endif
    end

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clock    (clock),
        .resetb   (resetb),
        .en       (sck_en),
        .sck      (flash_clk_o),
        .rise_stb (sck_rise),
        .fall_stb (sck_fall)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state        <= GAP;
            gap_cnt      <= GW'(CS_HIGH_CYC);
            bit_cnt      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            flash_csb_o  <= 1'b1;
            flash_io_o   <= 4'b1100;
            flash_io_oeb <= 4'b0010;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state         <= CMD;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        flash_csb_o   <= 1'b0;
                        bit_cnt       <= '0;
                        // First bit goes out with CSB; tx_sr holds the remaining 31 bits.
                        flash_io_o[0] <= RD_CMD[7];
                        tx_sr         <= {RD_CMD[6:0], req_addr & 24'hFFFFFC, 1'b0};
                    end
                end
                CMD: begin
                    if (sck_fall) begin
                        flash_io_o[0] <= tx_sr[31];
                        tx_sr         <= {tx_sr[30:0], 1'b0};
                        if (bit_cnt == 5'd7) begin
                            state   <= ADDR;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_fall) begin
                        if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                            state         <= DUMMY;
                            bit_cnt       <= '0;
                            flash_io_o[0] <= 1'b0;
                            flash_io_oeb  <= RX_OEB;
                        end else begin
                            flash_io_o[0] <= tx_sr[31];
                            tx_sr         <= {tx_sr[30:0], 1'b0};
                            bit_cnt       <= bit_cnt + 5'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_fall) begin
                        if (bit_cnt == 5'(DUMMY_CYC - 1)) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        rx_sr <= rx_next;
                    end
                    if (sck_fall) begin
                        if (bit_cnt == 5'(DATA_SCK - 1)) begin
                            state        <= RESP;
                            bit_cnt      <= '0;
                            flash_csb_o  <= 1'b1;
                            flash_io_o   <= 4'b1100;
                            flash_io_oeb <= 4'b0010;
                            rsp_valid    <= 1'b1;
                            rsp_data     <= bswap32(rx_sr);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= GAP;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        gap_cnt   <= GW'(CS_HIGH_CYC);
                    end
                end
                GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed bench for spi_flash_rd_ctrl with a behavioural SPI flash and an expected-response queue.
// Build with SPI_FLASH_QUAD_EN defined to exercise the quad read path (CLK_DIV=2).
`timescale 1ns/1ps
module tb_spi_flash_rd_ctrl;

`ifdef SPI_FLASH_QUAD_EN
    localparam int         CLK_DIV    = 2;
    localparam bit         QUAD       = 1'b1;
    localparam logic [7:0] EXP_CMD    = 8'h6B;
    localparam int         N_SCK      = 48;
    localparam logic [3:0] EXP_RX_OEB = 4'b1111;
`else
    localparam int         CLK_DIV    = 1;
    localparam bit         QUAD       = 1'b0;
    localparam logic [7:0] EXP_CMD    = 8'h0B;
    localparam int         N_SCK      = 72;
    localparam logic [3:0] EXP_RX_OEB = 4'b0011;
`endif
    localparam int CS_HIGH = 4;
    localparam int LAT     = 2 * CLK_DIV * N_SCK;

    logic        clock = 1'b0;
    logic        resetb;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        flash_csb_o;
    logic        flash_clk_o;
    logic [3:0]  flash_io_o;
    logic [3:0]  flash_io_oeb;
    logic [3:0]  flash_io_i = 4'b0000;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q[$];
    logic [31:0] exp_hdr_q[$];

    spi_flash_rd_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .CS_HIGH_CYC (CS_HIGH)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .flash_csb_o  (flash_csb_o),
        .flash_clk_o  (flash_clk_o),
        .flash_io_o   (flash_io_o),
        .flash_io_oeb (flash_io_oeb),
        .flash_io_i   (flash_io_i)
    );

    always #5 clock = ~clock;

    // Flash contents: a known word at 0x100, an address-derived pattern elsewhere.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Flash model: rc counts SCK rises since CSB fell.
    int          rc = 0;
    logic [31:0] mosi_sr = '0;
    logic [31:0] hdr_seen = '0;
    logic [31:0] stream = '0;
    logic [3:0]  oeb_cmd = '0;
    logic [3:0]  oeb_dmy = '0;
    logic [3:0]  oeb_dat = '0;

    always @(negedge flash_csb_o or posedge flash_clk_o) begin
        if (!flash_clk_o) begin
            rc      <= 0;
            mosi_sr <= '0;
        end else if (!flash_csb_o) begin
            if (rc < 32) mosi_sr <= {mosi_sr[30:0], flash_io_o[0]};
            if (rc == 31) begin
                logic [23:0] a;
                a = {mosi_sr[22:0], flash_io_o[0]};
                hdr_seen <= {mosi_sr[30:0], flash_io_o[0]};
                stream   <= {fbyte(a), fbyte(a + 24'd1), fbyte(a + 24'd2), fbyte(a + 24'd3)};
            end
            if (rc == 0)  oeb_cmd <= flash_io_oeb;
            if (rc == 36) oeb_dmy <= flash_io_oeb;
            if (rc == 44) oeb_dat <= flash_io_oeb;
            rc <= rc + 1;
        end
    end

    always @(negedge flash_clk_o) begin
        if (!flash_csb_o && rc >= 40) begin
            if (QUAD) begin
                if (rc < 48) flash_io_i <= stream[31 - 4 * (rc - 40) -: 4];
            end else if (rc < 72) begin
                flash_io_i[1] <= stream[31 - (rc - 40)];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [23:0] addr);
        logic [23:0] a;
        a = {addr[23:2], 2'b00};
        exp_data_q.push_back({fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)});
        exp_hdr_q.push_back({EXP_CMD, a});
    endtask

    task automatic issue(input logic [23:0] addr);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        push_exp(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check("accept_csb", 32'(flash_csb_o), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        logic [31:0] ed;
        logic [31:0] eh;
        while (!rsp_valid && n < LAT + 50) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        if (exp_data_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_data_q.size()), 32'd1);
        end else begin
            ed = exp_data_q.pop_front();
            eh = exp_hdr_q.pop_front();
            check("rsp_data", rsp_data, ed);
            check("mosi_header", hdr_seen, eh);
            check("oeb_cmd", 32'(oeb_cmd), 32'(4'b0010));
            check("oeb_dummy", 32'(oeb_dmy), 32'(EXP_RX_OEB));
            check("oeb_data", 32'(oeb_dat), 32'(EXP_RX_OEB));
            check("csb_after_frame", 32'(flash_csb_o), 32'd1);
        end
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        stable;
        logic [31:0] held;

        resetb    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_csb", 32'(flash_csb_o), 32'd1);
        check("rst_clk", 32'(flash_clk_o), 32'd0);
        check("rst_io_o", 32'(flash_io_o), 32'(4'b1100));
        check("rst_oeb", 32'(flash_io_oeb), 32'(4'b0010));
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", {31'd0, rsp_valid} | rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        resetb = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("post_reset_gap", 32'(n), 32'(CS_HIGH));
        repeat (20) tick();
        check("idle_csb", 32'(flash_csb_o), 32'd1);
        check("idle_clk", 32'(flash_clk_o), 32'd0);
        check("idle_oeb", 32'(flash_io_oeb), 32'(4'b0010));
        check("idle_ready", 32'(req_ready), 32'd1);

        issue(24'h000100);
        wait_rsp();
        complete();

        issue(24'h000103);
        wait_rsp();
        complete();

        // Stalled consumer, then back-to-back request held against the CSB gap.
        issue(24'h000200);
        wait_rsp();
        held   = rsp_data;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        push_exp(24'h000204);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 24'h000204;
        tick();
        rsp_ready = 1'b0;
        check("hold_release", 32'(rsp_valid), 32'd0);
        n = 0;
        while (flash_csb_o && n < 50) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("gap_accept_delay", 32'(n), 32'(CS_HIGH + 1));
        wait_rsp();
        complete();

        // Abort in the address phase; the partial frame must be discarded.
        issue(24'h000300);
        void'(exp_data_q.pop_back());
        void'(exp_hdr_q.pop_back());
        repeat (30 * CLK_DIV) tick();
        resetb = 1'b0;
        #1;
        check("abort_csb", 32'(flash_csb_o), 32'd1);
        check("abort_clk", 32'(flash_clk_o), 32'd0);
        check("abort_oeb", 32'(flash_io_oeb), 32'(4'b0010));
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        resetb = 1'b1;
        issue(24'h000100);
        wait_rsp();
        complete();

        issue(24'h0003FE);
        wait_rsp();
        complete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
